// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem reads at pc_in, registers returned
// instructions into the IF/ID boundary, and buffers one response across decode stalls.
module fetch_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  input  logic               stall,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid
);

  typedef enum logic [1:0] {FETCH, STALLED, STALLED_FULL} state_t;

  state_t              state, state_nx;
  logic                redirect;
  logic                inflight, inflight_nx;
  logic [ADDR_W-1:0]   inflight_pc, inflight_pc_nx;
  logic                skid_valid, skid_valid_nx;
  logic [INSTR_W-1:0]  skid_instr, skid_instr_nx;
  logic [ADDR_W-1:0]   skid_pc, skid_pc_nx;
  logic                if_valid_nx;
  logic [INSTR_W-1:0]  if_instr_nx;
  logic [ADDR_W-1:0]   if_pc_nx;

  assign redirect  = branch_taken | flush;
  assign imem_addr = pc_in;
  assign imem_rd   = !reset && !redirect && !stall;

  // Address the PC register loads next; a flush refetches the discarded address.
  always_comb begin
    pc_next = pc_in + ADDR_W'(1);
    if (reset)                pc_next = '0;
    else if (branch_taken)    pc_next = branch_target;
    else if (flush || stall)  pc_next = pc_in;
  end

  always_comb begin
    state_nx       = state;
    inflight_nx    = inflight;
    inflight_pc_nx = inflight_pc;
    skid_valid_nx  = skid_valid;
    skid_instr_nx  = skid_instr;
    skid_pc_nx     = skid_pc;
    if_valid_nx    = if_valid;
    if_instr_nx    = if_instr;
    if_pc_nx       = if_pc;

    if (redirect) begin
      // Drop everything, including any response arriving this cycle.
      if_valid_nx   = 1'b0;
      skid_valid_nx = 1'b0;
      inflight_nx   = 1'b0;
      state_nx      = FETCH;
    end else begin
      inflight_nx    = imem_rd;
      inflight_pc_nx = pc_in;
      unique case (state)
        FETCH, STALLED: begin
          if (inflight) begin
            if (stall && if_valid) begin
              skid_valid_nx = 1'b1;
              skid_instr_nx = imem_data;
              skid_pc_nx    = inflight_pc;
            end else begin
              if_valid_nx = 1'b1;
              if_instr_nx = imem_data;
              if_pc_nx    = inflight_pc;
            end
          end else if (!stall) begin
            if_valid_nx = 1'b0;
          end
          if (!stall)                      state_nx = FETCH;
          else if (inflight && if_valid)   state_nx = STALLED_FULL;
          else                             state_nx = STALLED;
        end
        STALLED_FULL: begin
          if (!stall) begin
            if_valid_nx   = 1'b1;
            if_instr_nx   = skid_instr;
            if_pc_nx      = skid_pc;
            skid_valid_nx = 1'b0;
            state_nx      = FETCH;
          end
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
    end else begin
      inflight    <= inflight_nx;
      inflight_pc <= inflight_pc_nx;
      skid_valid  <= skid_valid_nx;
      skid_instr  <= skid_instr_nx;
      skid_pc     <= skid_pc_nx;
      if_valid    <= if_valid_nx;
      if_instr    <= if_instr_nx;
      if_pc       <= if_pc_nx;
    end
  end

  // A returning response and a full skid buffer never compete for the output register.
  assert property (@(posedge clk) disable iff (reset) !(inflight && skid_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/reset
// traffic, all compared against a queue-based model of the IF/ID stream.
module tb_fetch_stage;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;

  logic               clk, reset, branch_taken, flush, stall, imem_rd, if_valid;
  logic [ADDR_W-1:0]  pc_in, pc_next, branch_target, imem_addr, if_pc;
  logic [INSTR_W-1:0] imem_data, if_instr;

  typedef struct packed {logic [7:0] pc; logic [31:0] ins;} ent_t;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  ent_t        resp_q[$];
  ent_t        hold_q[$];
  logic        m_valid;
  logic [7:0]  m_pc;
  logic [31:0] m_ins;
  logic        exp_rd, obs_rd, obs_valid;
  logic [7:0]  exp_next, obs_addr, obs_next, obs_pc;
  logic [31:0] obs_instr;
  logic [57:0] exp_vec, obs_vec;

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flush(flush), .stall(stall), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory; junk on cycles without a read.
  always @(posedge clk)
    imem_data <= imem_rd ? mem[imem_addr] : $urandom;

  // One clock of stimulus; the model treats IF/ID as a stream fed in issue order.
  task automatic step(input logic rst, input logic st, input logic bt,
                      input logic fl, input logic [7:0] tgt);
    ent_t lst[$];
    ent_t e;
    logic [7:0] ea;
    reset = rst; stall = st; branch_taken = bt; flush = fl; branch_target = tgt;
    #1;
    obs_rd = imem_rd; obs_addr = imem_addr; obs_next = pc_next;
    ea = pc_in;
    exp_rd = !rst && !(bt || fl) && !st;
    if (rst)            exp_next = 8'h00;
    else if (bt)        exp_next = tgt;
    else if (fl || st)  exp_next = pc_in;
    else                exp_next = pc_in + 8'd1;
    if (rst || bt || fl) begin
      resp_q.delete(); hold_q.delete(); m_valid = 1'b0;
      if (rst) begin m_pc = 8'h00; m_ins = 32'h0; end
    end else begin
      lst = hold_q;
      if (resp_q.size() > 0) lst.push_back(resp_q[0]);
      resp_q.delete();
      if (!st || !m_valid) begin
        if (lst.size() > 0) begin
          e = lst.pop_front(); m_pc = e.pc; m_ins = e.ins; m_valid = 1'b1;
        end else if (!st) m_valid = 1'b0;
      end
      hold_q = lst;
    end
    if (exp_rd) begin e = {pc_in, mem[pc_in]}; resp_q.push_back(e); end
    @(posedge clk); #1;
    obs_valid = if_valid; obs_pc = if_pc; obs_instr = if_instr;
    exp_vec = {exp_rd, ea, exp_next, m_valid, m_valid ? m_pc : 8'h00, m_valid ? m_ins : 32'h0};
    obs_vec = {obs_rd, obs_addr, obs_next, obs_valid, obs_valid ? obs_pc : 8'h00,
               obs_valid ? obs_instr : 32'h0};
    @(negedge clk);
    pc_in = exp_next;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
      checks++;
      if ({obs_rd, obs_next} !== 9'h0) begin
        errors++; $display("FAIL reset_comb: rd/next=%h expected 0", {obs_rd, obs_next});
      end
      checks++;
      if ({obs_valid, obs_pc, obs_instr} !== 41'h0) begin
        errors++; $display("FAIL reset_regs: valid/pc/instr=%h expected 0", {obs_valid, obs_pc, obs_instr});
      end
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL seq_model: dut=%h ref=%h", obs_vec, exp_vec); end
      checks++;
      if (obs_addr !== 8'(i)) begin errors++; $display("FAIL seq_addr: got %h expected %h", obs_addr, 8'(i)); end
      if (i == 0) begin
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL seq_first_invalid: valid=%b expected 0", obs_valid); end
      end else begin
        checks++;
        if ({obs_valid, obs_pc, obs_instr} !== {1'b1, 8'(i - 1), 32'hA000_0000 + 32'(i - 1)}) begin
          errors++; $display("FAIL seq_out: got %h expected %h", {obs_valid, obs_pc, obs_instr},
                             {1'b1, 8'(i - 1), 32'hA000_0000 + 32'(i - 1)});
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] frozen, p;
    frozen = m_pc;
    for (int i = 0; i < 3; i++) begin
      p = pc_in;
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL stall_model: dut=%h ref=%h", obs_vec, exp_vec); end
      checks++;
      if ({obs_rd, obs_next, obs_valid, obs_pc} !== {1'b0, p, 1'b1, frozen}) begin
        errors++; $display("FAIL stall_hold: got %h expected %h", {obs_rd, obs_next, obs_valid, obs_pc},
                           {1'b0, p, 1'b1, frozen});
      end
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL stall_rel_model: dut=%h ref=%h", obs_vec, exp_vec); end
      checks++;
      if ({obs_valid, obs_pc} !== {1'b1, frozen + 8'(i)}) begin
        errors++; $display("FAIL stall_release_seq: got %h expected %h", {obs_valid, obs_pc}, {1'b1, frozen + 8'(i)});
      end
    end
  endtask

  task automatic test_branch();
    pc_in = 8'h03;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
    checks++;
    if ({obs_rd, obs_next, obs_valid} !== {1'b0, 8'h40, 1'b0}) begin
      errors++; $display("FAIL branch_redirect: got %h expected %h", {obs_rd, obs_next, obs_valid}, {1'b0, 8'h40, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({obs_rd, obs_addr, obs_valid} !== {1'b1, 8'h40, 1'b0}) begin
      errors++; $display("FAIL branch_refetch: got %h expected %h", {obs_rd, obs_addr, obs_valid}, {1'b1, 8'h40, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL branch_model: dut=%h ref=%h", obs_vec, exp_vec); end
      checks++;
      if ({obs_valid, obs_pc, obs_instr} !== {1'b1, 8'h40 + 8'(i), 32'hA000_0040 + 32'(i)}) begin
        errors++; $display("FAIL branch_target_seq: got %h expected %h", {obs_valid, obs_pc, obs_instr},
                           {1'b1, 8'h40 + 8'(i), 32'hA000_0040 + 32'(i)});
      end
    end
  endtask

  task automatic test_flush_full();
    logic [7:0] held;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_vec !== exp_vec) begin errors++; $display("FAIL flush_pre_model: dut=%h ref=%h", obs_vec, exp_vec); end
    held = pc_in;
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
    checks++;
    if ({obs_rd, obs_next, obs_valid} !== {1'b0, held, 1'b0}) begin
      errors++; $display("FAIL flush_full: got %h expected %h", {obs_rd, obs_next, obs_valid}, {1'b0, held, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({obs_rd, obs_addr, obs_valid} !== {1'b1, held, 1'b0}) begin
      errors++; $display("FAIL flush_restart: got %h expected %h", {obs_rd, obs_addr, obs_valid}, {1'b1, held, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({obs_valid, obs_pc} !== {1'b1, held}) begin
      errors++; $display("FAIL flush_first_out: got %h expected %h", {obs_valid, obs_pc}, {1'b1, held});
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seen[$];
    logic [7:0] wexp[4];
    wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    pc_in = 8'hFE;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL wrap_model: dut=%h ref=%h", obs_vec, exp_vec); end
      if (obs_addr == 8'hFF) begin
        checks++;
        if (obs_next !== 8'h00) begin errors++; $display("FAIL wrap_next: got %h expected 00", obs_next); end
      end
      if (obs_valid === 1'b1) seen.push_back(obs_pc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= seen.size()) begin
        errors++; $display("FAIL wrap_seq[%0d]: missing, expected %h", k, wexp[k]);
      end else if (seen[k] !== wexp[k]) begin
        errors++; $display("FAIL wrap_seq[%0d]: got %h expected %h", k, seen[k], wexp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({obs_rd, obs_next, obs_valid, obs_pc, obs_instr} !== 50'h0) begin
      errors++; $display("FAIL rst_stall_clear: got %h expected 0", {obs_rd, obs_next, obs_valid, obs_pc, obs_instr});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({obs_rd, obs_addr, obs_valid} !== {1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL rst_stall_restart: got %h expected %h", {obs_rd, obs_addr, obs_valid}, {1'b1, 8'h00, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if ({obs_valid, obs_pc, obs_instr} !== {1'b1, 8'(i), 32'hA000_0000 + 32'(i)}) begin
        errors++; $display("FAIL rst_stall_seq: got %h expected %h", {obs_valid, obs_pc, obs_instr},
                           {1'b1, 8'(i), 32'hA000_0000 + 32'(i)});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0, 8'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_model[%0d]: dut=%h ref=%h", i, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    m_valid = 1'b0; m_pc = 8'h00; m_ins = 32'h0;
    pc_in = 8'h00; reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; flush = 1'b0;
    branch_target = 8'h00;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_flush_full();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly downstream of the PC register. It takes the current PC, issues reads to the synchronous instruction memory, and registers the returned instruction into the IF/ID boundary with a valid flag. It computes the next PC value (sequential or branch target) that drives the PC register's address input. A 1-entry skid buffer ensures no instruction is lost during decode stalls.

Parameters:
ADDR_W, 8, width of PC and instruction-memory address
INSTR_W, 32, instruction word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
pc_in  input  ADDR_W  current PC from the PC register
pc_next  output  ADDR_W  address the PC register loads at the next edge (combinational)
branch_taken  input  1  redirect request from execute; implies flush
branch_target  input  ADDR_W  redirect address, valid with branch_taken
flush  input  1  discard all fetched and in-flight instructions
stall  input  1  decode cannot accept; hold the IF/ID outputs
imem_addr  output  ADDR_W  instruction-memory read address (combinational, equals pc_in)
imem_rd  output  1  read strobe (combinational)
imem_data  input  INSTR_W  read data, valid exactly one cycle after imem_rd=1
if_instr  output  INSTR_W  registered instruction to decode
if_pc  output  ADDR_W  registered PC of if_instr
if_valid  output  1  if_instr/if_pc hold a live instruction

Behaviour:
- Reset, sampled at a clock edge: if_valid, if_instr, if_pc, the skid buffer, and the in-flight flag all clear to 0.
- Reset, combinational outputs: while reset=1, imem_rd=0 and pc_next=0.
- redirect = branch_taken | flush. Priority: reset > redirect > stall > normal.
- Issue rule: imem_rd = !reset & !redirect & !stall. The in-flight flag and the in-flight PC register imem_rd and pc_in. At most one request is ever outstanding.
- pc_next:
  - reset: 0
  - branch_taken: branch_target
  - flush only: pc_in (refetch the discarded address)
  - stall: pc_in
  - otherwise: pc_in+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00)
- Latency: address issued in cycle N; imem_data is sampled in cycle N+1; the instruction is visible on if_* in cycle N+2 when not stalled.
- States (derived from if_valid, skid_valid, and stall): FETCH, STALLED, STALLED_FULL.
  - FETCH: a returning response loads if_* (if_valid=1). With no response, if_valid<=0. A new request is issued each cycle.
    - stall=1 and if_valid=1 and response arriving: response goes to the skid buffer; go to STALLED_FULL.
    - stall=1 otherwise: go to STALLED.
  - STALLED: if_* hold. A response arriving here (issued in the last FETCH cycle) fills the skid buffer if if_valid=1, otherwise it loads if_*.
    - stall=0: return to FETCH.
  - STALLED_FULL: if_* and the skid buffer hold. No response can arrive.
    - stall=0: if_* <= skid and the skid buffer clears. A new request is issued the same cycle. Go to FETCH.
  - Invariant: a response and a valid skid buffer never need the output register in the same cycle. An assertion must check this.
- Redirect (any state): at the edge, if_valid<=0, skid_valid<=0, and in-flight<=0. Any imem_data arriving that cycle is dropped. No issue that cycle. Next state is FETCH.
- Stall with if_valid=0 and no response: no-op.
- Redirect while stalled overrides stall.
- Reset mid-stall or mid-flight: all state is discarded. Fetch restarts from pc_in (0 from the PC register) in the first cycle after reset deasserts.

Test Plan:
- Reset, then release with pc_in following pc_next, imem returning 32'hA000_0000+addr -> imem_addr sequence 0,1,2…; first if_valid=1 two cycles after release with if_pc=0, if_instr=32'hA000_0000; then one new instruction per cycle.
- Assert stall for 3 cycles while an instruction is in flight -> if_* frozen at the older instruction; skid captures the in-flight one; imem_rd=0 and pc_next=pc_in throughout. On release, if_* shows the skid contents the next cycle; no duplicates or gaps in the if_pc sequence.
- branch_taken=1, branch_target=8'h40 while pc_in=8'h05 -> pc_next=8'h40; if_valid=0 next cycle; the in-flight response for 0x04 is dropped; next valid if_pc=8'h40 two cycles after the redirect.
- flush in STALLED_FULL with stall still high -> if_valid=0, skid cleared; fetch restarts at the held pc_in the following cycle.
- pc_in=8'hFF in FETCH -> pc_next=8'h00; if_pc sequence FE, FF, 00, 01.
- Assert reset mid-stall with the skid full -> all outputs 0 next edge; after release, fetch resumes from address 0 with no stale instruction emitted.
